imm_encoder: RTL and testbench

Streaming LEGv8 instruction encoder: packs a 64-bit signed immediate plus register/opcode fields into a 32-bit B, CBZ or D-type instruction word. It performs the inverse of the decode-side sign extension. It range-checks the immediate against its field width, registers the result through a one-stage encode pipeline, and buffers it in a small output FIFO behind valid/ready handshakes. It feeds the instruction-memory loader and the self-check path that compares re-encoded words against fetched ones.

---
 rtl/lv8_pkg.sv | 36 +++
 rtl/imm_encoder_if.sv | 27 ++
 rtl/imm_fifo.sv | 44 ++++
 rtl/imm_encoder.sv | 85 ++++++++
 tb/tb_imm_encoder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lv8_pkg.sv
// Shared LEGv8 encode/decode constants, format enum and the immediate range helper.
package lv8_pkg;

   typedef enum logic [1:0] {
      FMT_D   = 2'd0,
      FMT_B   = 2'd1,
      FMT_CBZ = 2'd2,
      FMT_ILL = 2'd3
   } fmt_e;

   localparam logic [5:0] OP_B   = 6'b000101;
   localparam logic [7:0] OP_CBZ = 8'b10110100;

   localparam int unsigned B_W   = 26;
   localparam int unsigned CBZ_W = 19;
   localparam int unsigned D_W   = 9;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned IMM_W   = 64;

   // Encoded word as carried through S1 and the output FIFO.
   typedef struct packed {
      logic               err;
      logic [INSTR_W-1:0] instr;
   } enc_word_t;

   localparam int unsigned ENC_W = $bits(enc_word_t);

   // True when imm equals the sign extension of its low n bits.
   function automatic logic imm_fits(input logic [IMM_W-1:0] imm, input int unsigned n);
      logic signed [IMM_W-1:0] upper;
      upper = $signed(imm) >>> (n - 1);
      return (upper == '0) || (upper == '1);
   endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle of the immediate encoder.
interface imm_encoder_if #(
   parameter int unsigned ERRW = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_fmt;
   logic [10:0]      in_dop;
   logic [4:0]       in_rn;
   logic [4:0]       in_rt;
   logic [63:0]      in_imm;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic             out_err;
   logic [ERRW-1:0]  err_count;

   modport master (
      output in_valid, in_fmt, in_dop, in_rn, in_rt, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_err, err_count
   );

   modport slave (
      input  in_valid, in_fmt, in_dop, in_rn, in_rt, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_err, err_count
   );
endinterface

// File: rtl/imm_fifo.sv
// Circular output buffer with wrapping pointers and an occupancy count.
module imm_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 33
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= din;
   end

   // Pointers and count; push and pop together leave count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout = mem[rptr];

endmodule

// File: rtl/imm_encoder.sv
// LEGv8 B/CBZ/D instruction encoder: pack, range-check, S1 register, output FIFO.
module imm_encoder
   import lv8_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ERRW  = 16
) (
   input  logic          clk,
   input  logic          rst,
   imm_encoder_if.slave  bus
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   enc_word_t        enc_c;
   enc_word_t        s1_word;
   logic             s1_valid;
   enc_word_t        head;
   logic [CW-1:0]    fifo_count;
   logic [CW-1:0]    occupancy;
   logic             accept;
   logic             pop;
   logic [ERRW-1:0]  err_cnt;

   // Field packing and range check ahead of S1.
   always_comb begin
      enc_c = '0;
      unique case (fmt_e'(bus.in_fmt))
         FMT_B: begin
            enc_c.instr = {OP_B, bus.in_imm[B_W-1:0]};
            enc_c.err   = ~imm_fits(bus.in_imm, B_W);
         end
         FMT_CBZ: begin
            enc_c.instr = {OP_CBZ, bus.in_imm[CBZ_W-1:0], bus.in_rt};
            enc_c.err   = ~imm_fits(bus.in_imm, CBZ_W);
         end
         FMT_D: begin
            enc_c.instr = {bus.in_dop, bus.in_imm[D_W-1:0], 2'b00, bus.in_rn, bus.in_rt};
            enc_c.err   = ~imm_fits(bus.in_imm, D_W);
         end
         default: begin
            enc_c.instr = '0;
            enc_c.err   = 1'b1;
         end
      endcase
   end

   // Credit: S1 plus FIFO never exceed DEPTH, so S1 always drains into the FIFO.
   assign occupancy    = fifo_count + CW'(s1_valid);
   assign bus.in_ready = occupancy < CW'(DEPTH);
   assign accept       = bus.in_valid & bus.in_ready;

   // S1 pipeline register.
   always_ff @(posedge clk) begin
      if (rst) s1_valid <= 1'b0;
      else     s1_valid <= accept;
      if (accept) s1_word <= enc_c;
   end

   imm_fifo #(
      .DEPTH (DEPTH),
      .W     (ENC_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s1_valid),
      .din   (s1_word),
      .pop   (pop),
      .dout  (head),
      .count (fifo_count)
   );

   assign bus.out_valid = fifo_count != '0;
   assign pop           = bus.out_valid & bus.out_ready;
   assign bus.out_instr = bus.out_valid ? head.instr : '0;
   assign bus.out_err   = bus.out_valid & head.err;

   // Saturating count of emitted error words.
   always_ff @(posedge clk) begin
      if (rst)                                   err_cnt <= '0;
      else if (pop && head.err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
   end

   assign bus.err_count = err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed cases plus randomized traffic.
module tb_imm_encoder;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned ERRW  = 16;

   typedef struct {
      logic [31:0] instr;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imm_encoder_if #(.ERRW(ERRW)) bus ();

   imm_encoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   int   model_errs = 0;
   logic stall_prev = 1'b0;
   logic [31:0] prev_instr = '0;
   logic rand_ready = 1'b0;

   // Reference: immediate range from arithmetic bounds, fields by shift/mask.
   function automatic exp_t model(input logic [1:0] fmt, input logic [10:0] dop,
                                  input logic [4:0] rn, input logic [4:0] rt,
                                  input longint imm);
      exp_t e;
      int n;
      longint lo, hi;
      longint unsigned field;
      longint unsigned w;
      case (fmt)
         2'd0:    n = 9;
         2'd1:    n = 26;
         2'd2:    n = 19;
         default: n = 0;
      endcase
      if (n == 0) begin
         e.instr = 32'h0;
         e.err   = 1'b1;
         return e;
      end
      lo    = -(longint'(1) <<< (n - 1));
      hi    = (longint'(1) <<< (n - 1)) - 1;
      e.err = (imm < lo) || (imm > hi);
      field = longint'(imm) & ((64'd1 << n) - 64'd1);
      if (fmt == 2'd1)
         w = (64'd5 << 26) | field;
      else if (fmt == 2'd2)
         w = (64'hB4 << 24) | (field << 5) | 64'(rt);
      else
         w = (64'(dop) << 21) | (field << 12) | (64'(rn) << 5) | 64'(rt);
      e.instr = w[31:0];
      return e;
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: pushes expected words on input handshakes, pops and compares on output handshakes.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         exp_q.delete();
         model_errs = 0;
         stall_prev = 1'b0;
      end else begin
         check("err_count", longint'(bus.err_count), longint'(model_errs));
         if (stall_prev) check("stall_stable", longint'(bus.out_instr), longint'(prev_instr));
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_instr", longint'(bus.out_instr), longint'(e.instr));
               check("out_err", longint'(bus.out_err), longint'(e.err));
               if (bus.out_err && model_errs < 65535) model_errs++;
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_fmt, bus.in_dop, bus.in_rn, bus.in_rt, longint'(bus.in_imm)));
         stall_prev = bus.out_valid & ~bus.out_ready;
         prev_instr = bus.out_instr;
      end
   end

   task automatic set_req(input logic [1:0] fmt, input logic [10:0] dop,
                          input logic [4:0] rn, input logic [4:0] rt, input longint imm);
      bus.in_fmt = fmt;
      bus.in_dop = dop;
      bus.in_rn  = rn;
      bus.in_rt  = rt;
      bus.in_imm = 64'(imm);
   endtask

   // Issue one request and hold it until accepted; entered and left at posedge+1.
   task automatic send(input logic [1:0] fmt, input logic [10:0] dop,
                       input logic [4:0] rn, input logic [4:0] rt, input longint imm);
      int   n = 0;
      logic ok;
      set_req(fmt, dop, rn, rt, imm);
      bus.in_valid = 1'b1;
      do begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         if (rand_ready) bus.out_ready = ($urandom % 4) != 0;
         n++;
      end while (!ok && n < 200);
      if (!ok) check("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int n = 0;
      bus.out_ready = 1'b1;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", longint'(exp_q.size()), 0);
   endtask

   task automatic send_rand();
      logic [1:0] fmt;
      longint     imm;
      fmt = 2'($urandom_range(0, 3));
      imm = longint'({$urandom, $urandom}) >>> $urandom_range(0, 63);
      send(fmt, 11'($urandom), 5'($urandom), 5'($urandom), imm);
   endtask

   initial begin
      int acc;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      set_req(2'd0, '0, '0, '0, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_in_ready", longint'(bus.in_ready), 1);
      check("rst_out_valid", longint'(bus.out_valid), 0);
      check("rst_out_instr", longint'(bus.out_instr), 0);
      check("rst_out_err", longint'(bus.out_err), 0);
      check("rst_err_count", longint'(bus.err_count), 0);
      @(posedge clk);
      #1;

      // Latency: accepted at edge t, out_valid visible after edge t+1.
      set_req(2'd1, '0, '0, '0, -4);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("lat_accept", longint'(bus.in_ready), 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("lat_t0_valid", longint'(bus.out_valid), 0);
      @(negedge clk);
      check("lat_t1_valid", longint'(bus.out_valid), 1);
      check("lat_b_instr", longint'(bus.out_instr), 64'h17FFFFFC);
      @(posedge clk);
      #1;

      send(2'd2, '0, '0, 5'd3, 8);
      send(2'd0, 11'h7C2, 5'd2, 5'd1, 16);
      send(2'd0, 11'h7C2, 5'd2, 5'd1, 256);
      send(2'd3, '0, '0, '0, 0);
      send(2'd1, '0, '0, '0, (longint'(1) <<< 25) - 1);
      send(2'd1, '0, '0, '0, longint'(1) <<< 25);
      wait_empty();
      check("directed_err_count", longint'(bus.err_count), 3);

      // Backpressure: exactly DEPTH accepted while stalled.
      bus.out_ready = 1'b0;
      acc = 0;
      set_req(2'd1, '0, '0, '0, longint'($urandom_range(0, 1000)));
      bus.in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.in_ready) acc++;
         @(posedge clk);
         #1 set_req(2'd1, '0, '0, '0, longint'($urandom_range(0, 1000)));
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("stall_accepted", longint'(acc), longint'(DEPTH));
      check("stall_in_ready", longint'(bus.in_ready), 0);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      check("pre_pop_in_ready", longint'(bus.in_ready), 0);
      @(negedge clk);
      check("post_pop_in_ready", longint'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      wait_empty();

      // Randomized traffic with random output backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) send_rand();
      rand_ready = 1'b0;
      wait_empty();

      // Reset mid-stream with a coincident request.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(2'd3, '0, '0, '0, 0);
      set_req(2'd1, '0, '0, '0, 12);
      bus.in_valid = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", longint'(bus.out_valid), 0);
      check("midrst_err_count", longint'(bus.err_count), 0);
      check("midrst_in_ready", longint'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      send(2'd2, '0, '0, 5'd7, -1);
      wait_empty();
      repeat (3) @(posedge clk);
      #1;
      check("final_queue", longint'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
